control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Hardwired control unit that drives the datapath's control inputs each clock, replacing hand-sequenced stimulus.
- Runs fetch (T0-T2) then a per-opcode execute sequence (T3-T7), then returns to T0.
- Sits beside the datapath: reads the IR and the CON flip-flop, and drives every select, load, out and memory strobe.

Parameters:
- NSTEP, 8, number of T-steps T0..T7. Fixed; it exists only for state-width derivation.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge
- clear  in  1  reset, synchronous, active-high
- IR  in  32  instruction register; opcode is IR[31:27]
- CON_FF  in  1  branch condition flip-flop output
- Stop  in  1  halt request
- Run  out  1  high while executing; low in HALT and during reset
- opcode  out  5  ALU operation select
- Read, Write  out  1 each  memory strobes
- IncPC  out  1  ALU PC+1 mode
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-file select and enables
- HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Outportin, CONin  out  1 each  register loads
- HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout  out  1 each  bus drivers

Behaviour:
- State register: RESET, T0..T7, HALT.
- Outputs are a pure Moore decode of state and the latched opcode class; no output depends combinationally on CON_FF except in branch T6.
- Reset:
  - clear=1 forces RESET at the next edge, from any state including mid-execute and HALT.
  - In RESET: every control output is 0, Run=0, opcode=ADD (00011).
  - RESET always goes to T0.
- Default value of any control output not named for a step is 0. opcode defaults to ADD.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - If Stop=1 while in T0, next state is HALT instead of T1.
- Execute: the opcode class is decoded from IR in T3 (IR was loaded in T2). After the class's last step, the next state is T0.
  - R-ALU (add 3, sub 4, shr 5, shl 6, ror 7, rol 8, and 9, or 10):
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, Zin, opcode=IR[31:27].
    - T5: Zlowout, Gra, Rin.
  - Imm-ALU (addi 11, andi 12, ori 13):
    - T3: Grb, Rout, Yin.
    - T4: Cout, Zin, opcode=IR[31:27].
    - T5: Zlowout, Gra, Rin.
  - Unary (neg 16, not 17):
    - T3: Grb, Rout, Zin, opcode=IR[31:27].
    - T4: Zlowout, Gra, Rin.
  - Mul/div (mul 14, div 15):
    - T3: Gra, Rout, Yin.
    - T4: Grb, Rout, Zin, opcode=IR[31:27].
    - T5: Zlowout, LOin.
    - T6: Zhighout, HIin.
  - ldi (1):
    - T3: Grb, BAout, Yin.
    - T4: Cout, Zin.
    - T5: Zlowout, Gra, Rin.
  - ld (0):
    - T3-T4 as ldi.
    - T5: Zlowout, MARin.
    - T6: Read, MDRin.
    - T7: MDRout, Gra, Rin.
  - st (2):
    - T3-T5 as ld.
    - T6: Gra, Rout, MDRin (Read=0, so the MDR takes the bus).
    - T7: Write.
  - br (18):
    - T3: Gra, Rout, CONin.
    - T4: PCout, Yin.
    - T5: Cout, Zin.
    - T6: Zlowout and PCin, both only if CON_FF=1; otherwise no strobes.
  - jr (19): T3: Gra, Rout, PCin.
  - in (21): T3: Inportout, Gra, Rin.
  - out (22): T3: Gra, Rout, Outportin.
  - mfhi (23): T3: HIout, Gra, Rin.
  - mflo (24): T3: LOout, Gra, Rin.
  - nop (25) and all undefined opcodes: T3 has no strobes, then T0.
  - halt (26): T3 goes to HALT.
- HALT: all strobes 0 and Run=0. HALT is left only via clear.
- Run=1 in all of T0..T7.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - 5-bit opcode localparams (LD=0 … HALT=26, ADD=3).
  - State encoding (RESET, T0..T7, HALT).
  - Class encoding (R_ALU, IMM_ALU, UNARY, MULDIV, LDI, LD, ST, BR, JR, IN, OUT, MFHI, MFLO, NOP, HALT).
- One sub-module, ctrl_class_decode: combinational opcode→class decoder. The top-level block holds the state register, next-state logic and output decode.

Test Plan:
- clear=1 for 2 cycles from mid-T4, then clear=0 → all outputs 0 and Run=0 during reset; next state T0 with PCout=MARin=IncPC=Zin=1.
- IR=0x69080002 (ori r2,r1,2) → T3 Grb/Rout/Yin; T4 Cout/Zin with opcode=01101; T5 Zlowout/Gra/Rin; next cycle T0.
- IR=0x00000000 (ld) → the Read+MDRin pair is seen twice, at T1 and T6; T7 MDRout/Gra/Rin; 8 cycles total.
- br with CON_FF=0, then with CON_FF=1 → T6 has no strobes in the first case and Zlowout+PCin in the second.
- IR opcode 14 (mul) → T5 LOin with Zlowout; T6 HIin with Zhighout; opcode=01110 only in T4.
- IR opcode 26 (halt) → HALT after T3, Run=0 and stays 0 for 20 cycles; also Stop=1 at T0 → HALT with no T1 strobes. In both cases clear restores T0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, step
// states, opcode classes and the bundle of datapath control strobes.
package cpu_ctrl_pkg;

   localparam int NSTEP   = 8;
   localparam int STATE_W = $clog2(NSTEP + 2);

   localparam logic [4:0] OP_LD   = 5'd0;
   localparam logic [4:0] OP_LDI  = 5'd1;
   localparam logic [4:0] OP_ST   = 5'd2;
   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_SHR  = 5'd5;
   localparam logic [4:0] OP_SHL  = 5'd6;
   localparam logic [4:0] OP_ROR  = 5'd7;
   localparam logic [4:0] OP_ROL  = 5'd8;
   localparam logic [4:0] OP_AND  = 5'd9;
   localparam logic [4:0] OP_OR   = 5'd10;
   localparam logic [4:0] OP_ADDI = 5'd11;
   localparam logic [4:0] OP_ANDI = 5'd12;
   localparam logic [4:0] OP_ORI  = 5'd13;
   localparam logic [4:0] OP_MUL  = 5'd14;
   localparam logic [4:0] OP_DIV  = 5'd15;
   localparam logic [4:0] OP_NEG  = 5'd16;
   localparam logic [4:0] OP_NOT  = 5'd17;
   localparam logic [4:0] OP_BR   = 5'd18;
   localparam logic [4:0] OP_JR   = 5'd19;
   localparam logic [4:0] OP_IN   = 5'd21;
   localparam logic [4:0] OP_OUT  = 5'd22;
   localparam logic [4:0] OP_MFHI = 5'd23;
   localparam logic [4:0] OP_MFLO = 5'd24;
   localparam logic [4:0] OP_NOP  = 5'd25;
   localparam logic [4:0] OP_HALT = 5'd26;

   typedef enum logic [STATE_W-1:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      C_R_ALU, C_IMM_ALU, C_UNARY, C_MULDIV, C_LDI, C_LD, C_ST, C_BR,
      C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
   } class_t;

   // One bit per datapath control strobe; all-zero means "no strobes".
   typedef struct packed {
      logic read, write, inc_pc;
      logic gra, grb, grc, rin, rout, ba_out;
      logic hi_in, lo_in, y_in, z_in, pc_in, ir_in, mar_in, mdr_in;
      logic inport_in, outport_in, con_in;
      logic hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out;
      logic inport_out, c_out;
   } ctrl_t;

endpackage

// File: rtl/ctrl_class_decode.sv
// Combinational opcode to execute-class decoder.
module ctrl_class_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [4:0] i_opcode,
   output class_t     o_class
);

   // Map each opcode onto the execute sequence it shares; unknown codes act as nop.
   always_comb begin
      case (i_opcode)
         OP_ADD, OP_SUB, OP_SHR, OP_SHL,
         OP_ROR, OP_ROL, OP_AND, OP_OR:   o_class = C_R_ALU;
         OP_ADDI, OP_ANDI, OP_ORI:        o_class = C_IMM_ALU;
         OP_NEG, OP_NOT:                  o_class = C_UNARY;
         OP_MUL, OP_DIV:                  o_class = C_MULDIV;
         OP_LDI:                          o_class = C_LDI;
         OP_LD:                           o_class = C_LD;
         OP_ST:                           o_class = C_ST;
         OP_BR:                           o_class = C_BR;
         OP_JR:                           o_class = C_JR;
         OP_IN:                           o_class = C_IN;
         OP_OUT:                          o_class = C_OUT;
         OP_MFHI:                         o_class = C_MFHI;
         OP_MFLO:                         o_class = C_MFLO;
         OP_HALT:                         o_class = C_HALT;
         default:                         o_class = C_NOP;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch in T0-T2, per-class execute in T3-T7, then
// back to T0. Outputs are a Moore decode of the step and the opcode class.
module control_sequencer
   import cpu_ctrl_pkg::*;
(
   input  logic        Clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        CON_FF,
   input  logic        Stop,
   output logic        Run,
   output logic [4:0]  opcode,
   output logic        Read, Write, IncPC,
   output logic        Gra, Grb, Grc, Rin, Rout, BAout,
   output logic        HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin,
   output logic        Inportin, Outportin, CONin,
   output logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout,
   output logic        Inportout, Cout
);

   state_t     r_state, w_next;
   class_t     r_class, w_dec_class, w_class;
   logic [4:0] r_op, w_op;
   ctrl_t      w_ctl;
   logic       w_unused_ir;

   // Only the opcode field of IR steers the sequencer.
   assign w_unused_ir = ^IR[26:0];

   ctrl_class_decode u_class_decode (
      .i_opcode (IR[31:27]),
      .o_class  (w_dec_class)
   );

   // IR is fresh in T3; from T4 on the class latched at the end of T3 is used.
   assign w_class = (r_state == S_T3) ? w_dec_class : r_class;

   // State register plus opcode/class capture at the end of T3.
   always_ff @(posedge Clock) begin
      if (clear) begin
         r_state <= S_RESET;
         r_class <= C_NOP;
         r_op    <= OP_ADD;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         r_state <= w_next;
         if (r_state == S_T3) begin
            r_class <= w_dec_class;
            r_op    <= IR[31:27];
         end
      end
   end

   // Next-step sequencing; each class returns to T0 after its last step.
   always_comb begin
      // NOTE: default first so every path assigns w_next and no latch is inferred.
      w_next = r_state;
      case (r_state)
         S_RESET: w_next = S_T0;
         S_T0:    w_next = Stop ? S_HALT : S_T1;
         S_T1:    w_next = S_T2;
         S_T2:    w_next = S_T3;
         S_T3: begin
            case (w_class)
               C_HALT:                                    w_next = S_HALT;
               C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP:  w_next = S_T0;
               default:                                   w_next = S_T4;
            endcase
         end
         S_T4:    w_next = (w_class == C_UNARY) ? S_T0 : S_T5;
         S_T5:    w_next = (w_class inside {C_R_ALU, C_IMM_ALU, C_LDI}) ? S_T0 : S_T6;
         S_T6:    w_next = (w_class inside {C_LD, C_ST}) ? S_T7 : S_T0;
         S_T7:    w_next = S_T0;
         S_HALT:  w_next = S_HALT;
         default: w_next = S_RESET;
      endcase
   end

   // Control strobe decode for the current step and class.
   always_comb begin
      w_ctl = '0;
      w_op  = OP_ADD;
      case (r_state)
         S_T0: begin w_ctl.pc_out = 1'b1; w_ctl.mar_in = 1'b1; w_ctl.inc_pc = 1'b1; w_ctl.z_in = 1'b1; end
         S_T1: begin w_ctl.zlow_out = 1'b1; w_ctl.pc_in = 1'b1; w_ctl.read = 1'b1; w_ctl.mdr_in = 1'b1; end
         S_T2: begin w_ctl.mdr_out = 1'b1; w_ctl.ir_in = 1'b1; end
         S_T3: begin
            case (w_class)
               C_R_ALU, C_IMM_ALU: begin w_ctl.grb = 1'b1; w_ctl.rout = 1'b1; w_ctl.y_in = 1'b1; end
               C_UNARY: begin
                  w_ctl.grb = 1'b1; w_ctl.rout = 1'b1; w_ctl.z_in = 1'b1;
                  w_op = IR[31:27];
               end
               C_MULDIV:           begin w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.y_in = 1'b1; end
               C_LDI, C_LD, C_ST:  begin w_ctl.grb = 1'b1; w_ctl.ba_out = 1'b1; w_ctl.y_in = 1'b1; end
               C_BR:               begin w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.con_in = 1'b1; end
               C_JR:               begin w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.pc_in = 1'b1; end
               C_IN:               begin w_ctl.inport_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1; end
               C_OUT:              begin w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.outport_in = 1'b1; end
               C_MFHI:             begin w_ctl.hi_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1; end
               C_MFLO:             begin w_ctl.lo_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1; end
               default: ;
            endcase
         end
         S_T4: begin
            case (w_class)
               C_R_ALU:  begin w_ctl.grc = 1'b1; w_ctl.rout = 1'b1; w_ctl.z_in = 1'b1; w_op = r_op; end
               C_IMM_ALU: begin w_ctl.c_out = 1'b1; w_ctl.z_in = 1'b1; w_op = r_op; end
               C_UNARY:  begin w_ctl.zlow_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1; end
               C_MULDIV: begin w_ctl.grb = 1'b1; w_ctl.rout = 1'b1; w_ctl.z_in = 1'b1; w_op = r_op; end
               C_LDI, C_LD, C_ST: begin w_ctl.c_out = 1'b1; w_ctl.z_in = 1'b1; end
               C_BR:     begin w_ctl.pc_out = 1'b1; w_ctl.y_in = 1'b1; end
               default: ;
            endcase
         end
         S_T5: begin
            case (w_class)
               C_R_ALU, C_IMM_ALU, C_LDI: begin w_ctl.zlow_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1; end
               C_MULDIV:   begin w_ctl.zlow_out = 1'b1; w_ctl.lo_in = 1'b1; end
               C_LD, C_ST: begin w_ctl.zlow_out = 1'b1; w_ctl.mar_in = 1'b1; end
               C_BR:       begin w_ctl.c_out = 1'b1; w_ctl.z_in = 1'b1; end
               default: ;
            endcase
         end
         S_T6: begin
            case (w_class)
               C_MULDIV: begin w_ctl.zhigh_out = 1'b1; w_ctl.hi_in = 1'b1; end
               C_LD:     begin w_ctl.read = 1'b1; w_ctl.mdr_in = 1'b1; end
               // Read stays low so the MDR captures the register value off the bus.
               C_ST:     begin w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.mdr_in = 1'b1; end
               C_BR:     begin w_ctl.zlow_out = CON_FF; w_ctl.pc_in = CON_FF; end
               default: ;
            endcase
         end
         S_T7: begin
            case (w_class)
               C_LD:    begin w_ctl.mdr_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1; end
               C_ST:    w_ctl.write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign Run       = (r_state != S_RESET) && (r_state != S_HALT);
   assign opcode    = w_op;
   assign Read      = w_ctl.read;
   assign Write     = w_ctl.write;
   assign IncPC     = w_ctl.inc_pc;
   assign Gra       = w_ctl.gra;
   assign Grb       = w_ctl.grb;
   assign Grc       = w_ctl.grc;
   assign Rin       = w_ctl.rin;
   assign Rout      = w_ctl.rout;
   assign BAout     = w_ctl.ba_out;
   assign HIin      = w_ctl.hi_in;
   assign LOin      = w_ctl.lo_in;
   assign Yin       = w_ctl.y_in;
   assign Zin       = w_ctl.z_in;
   assign PCin      = w_ctl.pc_in;
   assign IRin      = w_ctl.ir_in;
   assign MARin     = w_ctl.mar_in;
   assign MDRin     = w_ctl.mdr_in;
   assign Inportin  = w_ctl.inport_in;
   assign Outportin = w_ctl.outport_in;
   assign CONin     = w_ctl.con_in;
   assign HIout     = w_ctl.hi_out;
   assign LOout     = w_ctl.lo_out;
   assign Zhighout  = w_ctl.zhigh_out;
   assign Zlowout   = w_ctl.zlow_out;
   assign PCout     = w_ctl.pc_out;
   assign MDRout    = w_ctl.mdr_out;
   assign Inportout = w_ctl.inport_out;
   assign Cout      = w_ctl.c_out;

endmodule
